// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program control and branch inputs in, ROM address and status out.
// The environment (decoder/ALU/host) uses master; the fetch unit uses slave.
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             BranchEn;
    logic             Zero;
    logic [2:0]       PCTarg;
    logic             Ack;
    logic             LutWrEn;
    logic [2:0]       LutWrIdx;
    logic [PC_W-1:0]  LutWrData;
    logic [PC_W-1:0]  ProgCtr;
    logic             InstrValid;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;

    modport master (
        output Start, BranchEn, Zero, PCTarg, Ack, LutWrEn, LutWrIdx, LutWrData,
        input  ProgCtr, InstrValid, Done, CycleCnt
    );

    modport slave (
        input  Start, BranchEn, Zero, PCTarg, Ack, LutWrEn, LutWrIdx, LutWrData,
        output ProgCtr, InstrValid, Done, CycleCnt
    );
endinterface

// File: rtl/fetch_unit.sv
// PC/fetch stage: IDLE/RUN/DONE sequencer, LUT-resolved branches, saturating cycle count.
// All outputs registered; branch target on ProgCtr one cycle after BranchEn&Zero; no stall.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    fetch_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  START_PC = START_ADDR[PC_W-1:0];
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_instr_valid;
    logic             r_done;
    logic [PC_W-1:0]  r_lut [8];

    logic [PC_W-1:0]  w_lut_rd;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_taken;

    assign w_lut_rd  = r_lut[bus.PCTarg];
    assign w_taken   = bus.BranchEn & bus.Zero;
    // Counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= START_PC;
            r_cnt         <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_lut[i] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && bus.LutWrEn) begin
                r_lut[bus.LutWrIdx] <= bus.LutWrData;
            end

            if (bus.Start) begin
                r_state       <= ST_IDLE;
                r_pc          <= START_PC;
                r_cnt         <= '0;
                r_instr_valid <= 1'b0;
                r_done        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_RUN;
                        r_instr_valid <= 1'b1;
                        r_done        <= 1'b0;
                    end
                    ST_RUN: begin
                        r_cnt <= w_cnt_inc;
                        if (bus.Ack) begin
                            r_state       <= ST_DONE;
                            r_instr_valid <= 1'b0;
                            r_done        <= 1'b1;
                        end else if (w_taken) begin
                            r_pc <= w_lut_rd;
                        end else begin
                            r_pc <= r_pc + PC_ONE;
                        end
                    end
                    ST_DONE: begin
                        r_instr_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_instr_valid <= 1'b0;
                        r_done        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ProgCtr    = r_pc;
    assign bus.InstrValid = r_instr_valid;
    assign bus.Done       = r_done;
    assign bus.CycleCnt   = r_cnt;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter / fetch stage of the 9-bit processor.
- Drives the instruction ROM address.
- Consumes the control decoder's BranchEn, PCTarg and Ack, plus the ALU Zero flag.
- Resolves branches through a small loadable target lookup table (LUT), runs a Start/Done program handshake, and counts executed cycles.

Parameters:
- PC_W, 10, width of program counter / ROM address.
- START_ADDR, 0, address loaded on restart (must fit in PC_W bits).
- CNT_W, 16, width of executed-cycle counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level; high = hold/restart, falling to low = begin program.
- BranchEn  input  1  branch instruction decoded.
- Zero  input  1  ALU zero flag for current instruction; branch condition.
- PCTarg  input  3  LUT index of branch target.
- Ack  input  1  halt instruction decoded.
- LutWrEn  input  1  write strobe for target LUT.
- LutWrIdx  input  3  LUT entry to write.
- LutWrData  input  PC_W  absolute target address to store.
- ProgCtr  output  PC_W  instruction ROM address.
- InstrValid  output  1  ProgCtr addresses an instruction being executed this cycle.
- Done  output  1  program halted.
- CycleCnt  output  CNT_W  RUN cycles executed since last restart.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, ProgCtr=START_ADDR, InstrValid=0, Done=0, CycleCnt=0.
  - All 8 LUT entries=0.
  - Reset asserted mid-program aborts immediately; no completion pulse.
- States: IDLE, RUN, DONE. All transitions occur on the rising Clk edge.
- Any state with Start=1: next state=IDLE, ProgCtr<=START_ADDR, CycleCnt<=0, Done<=0. Start=1 overrides Ack and branch.
- IDLE with Start=0: next state=RUN. ProgCtr stays START_ADDR, so the first executed instruction is START_ADDR.
- RUN, per cycle, priority order:
  1. Ack=1: next state=DONE, ProgCtr held, CycleCnt+1.
  2. BranchEn=1 and Zero=1: ProgCtr<=LUT[PCTarg], CycleCnt+1.
  3. Otherwise: ProgCtr<=ProgCtr+1, wrapping modulo 2^PC_W (all-ones -> 0), CycleCnt+1.
- BranchEn=1 with Zero=0 is treated as a plain increment.
- Ack and a taken branch in the same cycle: Ack wins.
- DONE with Start=0: ProgCtr, CycleCnt held. Done=1. Stays until Start=1.
- Output timing:
  - InstrValid = (state==RUN), registered with state.
  - Done = (state==DONE), registered with state.
  - Done rises the cycle after Ack is sampled; InstrValid falls on the same edge.
- CycleCnt saturates at 2^CNT_W-1 (no wrap). It counts the Ack cycle and every RUN cycle.
- LUT writes:
  - Accepted only when state==IDLE; ignored in RUN and DONE.
  - Written on the clock edge; visible to branches from the next cycle onward.
  - A write in the IDLE->RUN transition cycle is accepted.
  - Multiple writes to the same index: last write wins.
- LUT read is combinational from PCTarg. There is no read/write hazard, since reads are used only in RUN.
- Branch latency: target appears on ProgCtr one cycle after BranchEn&Zero are sampled. No delay slot, no stall.
- Inputs BranchEn, Zero, PCTarg, Ack are ignored outside RUN.

Test Plan:
- Reset, Start=1 for 3 cycles, LUT writes idx2=0x040 and idx5=0x3FE, then Start=0 -> ProgCtr=0, 0, 1, 2 on successive edges after Start falls; InstrValid=1 from first RUN cycle; CycleCnt increments by 1 each cycle.
- RUN at ProgCtr=0x005, BranchEn=1, Zero=1, PCTarg=2 -> next ProgCtr=0x040. Same stimulus with Zero=0 -> next ProgCtr=0x006.
- Branch to idx5 (0x3FE), then two plain cycles -> ProgCtr=0x3FE, 0x3FF, 0x000 (wrap).
- At ProgCtr=0x010, assert Ack together with BranchEn=1, Zero=1 -> ProgCtr stays 0x010, Done=1 next cycle, InstrValid=0, CycleCnt frozen. Start=1 then 0 -> Done=0, ProgCtr=0, CycleCnt=0, program reruns.
- LutWrEn with idx2=0x100 during RUN, then branch via idx2 -> ProgCtr=0x040 (write ignored).
- Assert Reset=0 asynchronously mid-RUN at ProgCtr=0x023 -> ProgCtr=0, Done=0, InstrValid=0, CycleCnt=0 immediately without a clock edge; LUT entries read 0.
